// File: rtl/param_mem_engine.sv
// Single-port memory engine: pipelined tagged reads with width extension, sticky status, clear sweep.
// Build option PARAM_MEM_OUTREG_EN adds an output register stage (read latency 3 instead of 2).
module param_mem_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 512,
  parameter int EXT_FACTOR = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             wr,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [1:0]                       ext_mode,
  input  logic                             clear,
  output logic                             ready,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            normal_data_out,
  output logic [EXT_FACTOR*DATA_WIDTH-1:0] extended_data_out,
  output logic [2*ADDR_WIDTH-1:0]          full_addr,
  output logic [3:0]                       status
);
  localparam int EXT_W = EXT_FACTOR * DATA_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [0:0]              state;
  logic [IDX_W-1:0]        sweep;
  logic [ADDR_WIDTH-1:0]   seq_tag;
  logic                    oob_err;
  logic                    tag_wrap;
  logic                    last_wr;
  logic                    accept;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;

  logic                    s1_valid;
  logic                    s1_oob;
  logic [1:0]              s1_mode;
  logic [2*ADDR_WIDTH-1:0] s1_full;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [EXT_W-1:0]        ext_word;

  logic                    p2_valid;
  logic [DATA_WIDTH-1:0]   p2_data;
  logic [EXT_W-1:0]        p2_ext;
  logic [2*ADDR_WIDTH-1:0] p2_full;

  assign ready    = (state == IDLE) && !clear && !reset;
  assign accept   = enable && ready;
  assign in_range = {1'b0, addr} < DEPTH_V;
  assign idx      = addr[IDX_W-1:0];
  assign status   = {last_wr, tag_wrap, oob_err, state == CLEAR};

  // Sweep owns the write port while clearing; no request can be accepted then.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[sweep] <= '0;
    else if (accept && wr && in_range)
      mem[idx] <= data_in;
    if (accept && !wr)
      s1_data <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sweep    <= '0;
      seq_tag  <= '0;
      oob_err  <= 1'b0;
      tag_wrap <= 1'b0;
      last_wr  <= 1'b0;
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_mode  <= '0;
      s1_full  <= '0;
    end else begin
      s1_valid <= accept && !wr;
      case (state)
        IDLE: begin
          if (clear) begin
            state    <= CLEAR;
            sweep    <= '0;
            oob_err  <= 1'b0;
            tag_wrap <= 1'b0;
          end
        end
        default: begin
          if (sweep == LAST_IDX)
            state <= IDLE;
          sweep <= sweep + 1'b1;
        end
      endcase
      if (accept) begin
        last_wr <= wr;
        if (!in_range)
          oob_err <= 1'b1;
        if (!wr) begin
          seq_tag <= seq_tag + 1'b1;
          if (&seq_tag)
            tag_wrap <= 1'b1;
          s1_oob  <= !in_range;
          s1_mode <= ext_mode;
          s1_full <= {seq_tag, addr};
        end
      end
    end
  end

  always_comb begin
    rd_word  = s1_oob ? '0 : s1_data;
    ext_word = '0;
    case (s1_mode)
      2'b00:   ext_word = {{(EXT_W - DATA_WIDTH){1'b0}}, rd_word};
      2'b01:   ext_word = {{(EXT_W - DATA_WIDTH){rd_word[DATA_WIDTH-1]}}, rd_word};
      2'b10:   ext_word = {EXT_FACTOR{rd_word}};
      default: ext_word = {rd_word, {(EXT_W - DATA_WIDTH){1'b0}}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p2_valid <= 1'b0;
      p2_data  <= '0;
      p2_ext   <= '0;
      p2_full  <= '0;
    end else begin
      p2_valid <= s1_valid;
      if (s1_valid) begin
        p2_data <= rd_word;
        p2_ext  <= ext_word;
        p2_full <= s1_full;
      end
    end
  end

`ifdef PARAM_MEM_OUTREG_EN
  logic                    o_valid;
  logic [DATA_WIDTH-1:0]   o_data;
  logic [EXT_W-1:0]        o_ext;
  logic [2*ADDR_WIDTH-1:0] o_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ext   <= '0;
      o_full  <= '0;
    end else begin
      o_valid <= p2_valid;
      if (p2_valid) begin
        o_data <= p2_data;
        o_ext  <= p2_ext;
        o_full <= p2_full;
      end
    end
  end

  assign rd_valid          = o_valid;
  assign normal_data_out   = o_data;
  assign extended_data_out = o_ext;
  assign full_addr         = o_full;
`else
  assign rd_valid          = p2_valid;
  assign normal_data_out   = p2_data;
  assign extended_data_out = p2_ext;
  assign full_addr         = p2_full;
`endif

endmodule

// File: tb/tb_param_mem_engine.sv
// Scoreboard bench for param_mem_engine: directed cases plus random traffic against an array model.
module tb_param_mem_engine;
`ifdef PARAM_MEM_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, wr, clear, ready, rd_valid;
  logic [11:0] addr;
  logic [15:0] data_in, normal_data_out;
  logic [1:0]  ext_mode;
  logic [47:0] extended_data_out;
  logic [23:0] full_addr;
  logic [3:0]  status;

  param_mem_engine #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(512), .EXT_FACTOR(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .ext_mode(ext_mode), .clear(clear), .ready(ready), .rd_valid(rd_valid),
    .normal_data_out(normal_data_out), .extended_data_out(extended_data_out),
    .full_addr(full_addr), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [47:0] e;
    logic [23:0] fa;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  logic [15:0] mdl_mem [512];
  int unsigned m_tag = 0;
  bit          m_oob = 0, m_wrap = 0, m_lastwr = 0;
  logic [15:0] last_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] ext_model(input logic [15:0] d, input logic [1:0] m);
    case (m)
      2'd0:    return 48'(d);
      2'd1:    return d[15] ? (48'hFFFF_FFFF_0000 | 48'(d)) : 48'(d);
      2'd2:    return 48'(d) * 48'h0001_0001_0001;
      default: return 48'(d) << 32;
    endcase
  endfunction

  task automatic chk_status(input string name);
    chk(name, status, {m_lastwr, m_wrap, m_oob, 1'b0});
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic op(input bit w, input logic [11:0] a, input logic [15:0] d, input logic [1:0] m);
    exp_t        e;
    logic [15:0] rd;
    chk("ready_before_req", ready, 1);
    enable = 1; wr = w; addr = a; data_in = d; ext_mode = m;
    @(posedge clk); #1;
    enable = 0;
    if (w) begin
      if (a < 512) mdl_mem[a] = d;
      else m_oob = 1;
      m_lastwr = 1;
    end else begin
      rd   = (a < 512) ? mdl_mem[a] : 16'h0;
      e.d  = rd;
      e.e  = ext_model(rd, m);
      e.fa = {12'(m_tag), a};
      e.cyc = cyc + LAT - 1;
      sbq.push_back(e);
      if (m_tag == 4095) m_wrap = 1;
      m_tag = (m_tag + 1) % 4096;
      if (a >= 512) m_oob = 1;
      m_lastwr = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_d = '0;
    end else if (rd_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rd_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_data", normal_data_out, e.d);
        chk("rd_ext", extended_data_out, e.e);
        chk("full_addr", full_addr, e.fa);
      end
      last_d = normal_data_out;
    end else begin
      chk("data_hold", normal_data_out, last_d);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  initial begin
    int          busy, rdy_bad, r;
    logic [11:0] a, oa;
    logic [15:0] d;
    logic [1:0]  m;

    reset = 1; enable = 0; wr = 0; addr = '0; data_in = '0; ext_mode = '0; clear = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_data", normal_data_out, 0);
      chk("rst_ext", extended_data_out, 0);
      chk("rst_full_addr", full_addr, 0);
      chk("rst_status", status, 0);
    end
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("ready_after_reset", ready, 1);
    @(posedge clk); #1;

    // Write then read in the next cycle.
    op(1, 12'h010, 16'hA5C3, 2'd0);
    chk_status("status_after_write");
    op(0, 12'h010, 16'h0, 2'd0);
    chk_status("status_after_read");

    // Extension modes on a negative word.
    op(1, 12'h020, 16'h8001, 2'd0);
    for (int k = 0; k < 4; k++) op(0, 12'h020, 16'h0, 2'(k));

    // Out-of-range read and write; the dropped write must not alias onto word 0.
    op(1, 12'h000, 16'h1234, 2'd0);
    op(0, 12'h200, 16'h0, 2'd0);
    chk_status("oob_read_status");
    op(1, 12'h200, 16'hBEEF, 2'd0);
    chk_status("oob_write_status");
    op(0, 12'h000, 16'h0, 2'd1);

    // In-flight read completes with pre-clear data; clear beats a same-cycle request.
    op(0, 12'h010, 16'h0, 2'd3);
    clear = 1; enable = 1; wr = 0; addr = 12'h010;
    #1;
    chk("ready_on_clear", ready, 0);
    @(posedge clk); #1;
    clear = 0; enable = 0;
    for (int i = 0; i < 512; i++) mdl_mem[i] = '0;
    m_oob = 0; m_wrap = 0;
    chk("clear_entry_status", status, {m_lastwr, 2'b00, 1'b1});
    busy = 0; rdy_bad = 0;
    while (status[0] && busy < 600) begin
      if (ready) rdy_bad++;
      busy++;
      @(posedge clk); #1;
    end
    chk("clear_cycles", busy, 512);
    chk("ready_low_in_clear", rdy_bad, 0);
    chk_status("status_after_clear");
    op(0, 12'h000, 16'h0, 2'd2);
    op(0, 12'h1FF, 16'h0, 2'd1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      a  = 12'($urandom_range(0, 511));
      oa = 12'($urandom_range(512, 4095));
      d  = 16'($urandom);
      m  = 2'($urandom_range(0, 3));
      case (r)
        0, 1, 2, 3: op(0, a, 16'h0, m);
        4, 5:       op(1, a, d, m);
        6:          op(0, oa, 16'h0, m);
        7:          op(1, oa, d, m);
        8:          begin @(posedge clk); #1; end
        default:    begin op(1, a, d, m); op(0, a, 16'h0, m); end
      endcase
      if (r != 8) chk_status("rand_status");
    end
    drain();

    // Reset part-way through a sweep; low words may be partially cleared.
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("ready_after_abort", ready, 1);
    chk("status_after_abort", status, 0);
    @(posedge clk); #1;
    m_tag = 0; m_oob = 0; m_wrap = 0; m_lastwr = 0;

    // Full tag cycle plus one, back to back.
    for (int i = 0; i < 4097; i++) begin
      if (i == 4095) chk("tag_wrap_before", status[2], 0);
      op(0, 12'($urandom_range(16, 511)), 16'h0, 2'($urandom_range(0, 3)));
    end
    chk("tag_wrap_after", status[2], 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
